// File: rtl/pwm_pkg.sv
// Shared constants and the duty compare rule for the PWM peripheral.
package pwm_pkg;

    localparam int PWM_RES             = 8;
    localparam int PWM_NUM_CH          = 16;
    localparam int PWM_CLK_DIV_DEFAULT = 13;

    typedef logic [PWM_RES-1:0] pwm_level_t;

    localparam pwm_level_t PWM_DUTY_FULL = 8'hFF;

    // Full-scale duty pins the output high for the whole period instead of
    // dropping low during the final count.
    function automatic logic pwm_compare(input pwm_level_t counter, input pwm_level_t duty);
        return (duty == PWM_DUTY_FULL) ? 1'b1 : (counter < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter shared by every PWM channel.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    output pwm_level_t counter,
    output logic       wrap
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    assign tick = (prescaler == PRE_LAST);
    assign wrap = tick && (&counter);

    // With CLK_DIV=1 the prescaler sits at zero and tick is asserted every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            counter   <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                counter   <= counter + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as off, static high or a shared PWM waveform from the SPI
// control registers; duty is shadowed so it only changes on period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            en_reg_out_7_0,
    input  logic [7:0]            en_reg_out_15_8,
    input  logic [7:0]            en_reg_pwm_7_0,
    input  logic [7:0]            en_reg_pwm_15_8,
    input  logic [7:0]            pwm_duty_cycle,
    output logic [PWM_NUM_CH-1:0] out,
    output logic                  period_start
);

    logic [PWM_NUM_CH-1:0] en_out;
    logic [PWM_NUM_CH-1:0] en_pwm;
    pwm_level_t            counter;
    pwm_level_t            duty_shadow;
    logic                  wrap;
    logic                  pwm_raw;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .counter (counter),
        .wrap    (wrap)
    );

    assign pwm_raw = pwm_compare(counter, duty_shadow);

    // A duty write landing on the wrap clk is captured, so the new period
    // always starts with the freshest requested value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow  <= '0;
            period_start <= 1'b0;
            out          <= '0;
        end else begin
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
            period_start <= wrap;
            out          <= en_out & (~en_pwm | {PWM_NUM_CH{pwm_raw}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral at CLK_DIV=13 and CLK_DIV=1 side by side.
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int DIV_S = 13;
    localparam int DIV_F = 1;
    localparam int PER   = 256 * DIV_S;

    typedef struct {
        logic [16:0] slow;
        logic [16:0] fast;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out_s;
    logic [15:0] out_f;
    logic        ps_s;
    logic        ps_f;

    exp_t        exp_q[$];
    exp_t        model_e;
    exp_t        mon_e;
    int          n_s;
    int          n_f;
    logic [7:0]  sh_s;
    logic [7:0]  sh_f;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(DIV_S)) dut_slow (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out_s),
        .period_start    (ps_s)
    );

    pwm_peripheral #(.CLK_DIV(DIV_F)) dut_fast (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out_f),
        .period_start    (ps_f)
    );

    // Expected {period_start, out} after the n-th clk since reset release:
    // the level is simply elapsed clks divided down, the period boundary is
    // every 256*div clks, and the PWM level uses the duty owned by this period.
    function automatic logic [16:0] expect_pins(input int n, input int div, input logic [7:0] shadow);
        int   level;
        logic raw;
        logic ps;
        level = ((n - 1) / div) % 256;
        raw   = (shadow == 8'hFF) || (level < int'(shadow));
        ps    = (n % (256 * div)) == 0;
        return {ps, en_out & (~en_pwm | {16{raw}})};
    endfunction

    task automatic checkOutput(input string name, input logic [16:0] actual, input logic [16:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got period_start=%0b out=%04h, expected period_start=%0b out=%04h",
                     name, $time, actual[16], actual[15:0], expected[16], expected[15:0]);
        end
    endtask

    task automatic applyStimulus(input int cycles, input bit rand_en, input bit rand_duty);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rand_en && $urandom_range(0, 63) == 0) begin
                en_out = 16'($urandom);
                en_pwm = 16'($urandom);
            end
            if (rand_duty) begin
                duty = 8'($urandom);
            end
        end
    endtask

    // Reference model: one expectation per clk edge, pushed for the monitor.
    always @(posedge clk) begin
        if (!rst_n) begin
            n_s          = 0;
            n_f          = 0;
            sh_s         = 8'h00;
            sh_f         = 8'h00;
            model_e.slow = '0;
            model_e.fast = '0;
        end else begin
            n_s++;
            n_f++;
            model_e.slow = expect_pins(n_s, DIV_S, sh_s);
            model_e.fast = expect_pins(n_f, DIV_F, sh_f);
            if (model_e.slow[16]) sh_s = duty;
            if (model_e.fast[16]) sh_f = duty;
        end
        exp_q.push_back(model_e);
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("slow_pins", {ps_s, out_s}, mon_e.slow);
            checkOutput("fast_pins", {ps_f, out_f}, mon_e.fast);
        end
    end

    initial begin
        rst_n  = 1'b0;
        en_out = 16'h0000;
        en_pwm = 16'h0000;
        duty   = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        en_out = 16'h00FF;
        duty   = 8'h80;
        applyStimulus(100, 1'b0, 1'b0);

        en_out = 16'h0001;
        en_pwm = 16'h0001;
        applyStimulus(2 * PER, 1'b0, 1'b0);

        en_out = 16'hFFF7;
        en_pwm = 16'hFFFF;
        applyStimulus(PER, 1'b0, 1'b0);

        duty = 8'h00;
        applyStimulus(PER, 1'b0, 1'b0);
        duty = 8'hFF;
        applyStimulus(2 * PER, 1'b0, 1'b0);

        duty = 8'h40;
        applyStimulus(PER + 1000, 1'b0, 1'b0);
        duty = 8'hC0;
        applyStimulus(2 * PER, 1'b0, 1'b0);

        applyStimulus(2 * PER, 1'b1, 1'b1);

        en_out = 16'hFFFF;
        en_pwm = 16'h0000;
        duty   = 8'h80;
        applyStimulus(1000, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_slow", {ps_s, out_s}, 17'h0);
        checkOutput("async_reset_fast", {ps_f, out_f}, 17'h0);
        repeat (2) @(negedge clk);
        en_pwm = 16'hF0F0;
        rst_n  = 1'b1;
        applyStimulus(PER + 100, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
